// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan byte sequencer: folds E0/F0/E1 prefix sequences into whole key events
// and buffers them in a show-ahead FIFO for the CPU keyboard port.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  IDLE    | waiting for the first byte of a sequence
//  EXT     | E0 seen, expecting code or F0
//  BRK     | F0 seen, expecting the released code
//  EXT_BRK | E0 F0 seen, expecting the released code
//  PAUSE   | E1 seen, swallowing the rest of the Pause sequence
module ps2_key_event_ctrl #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic                     ev_valid,
    output logic [9:0]               ev_data,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     err,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } state_t;

    state_t         state, state_nx;
    logic [2:0]     pause_cnt, pause_nx;
    logic [TW-1:0]  timer;
    logic           timeout_hit;
    logic           push_nx, fsm_err;
    logic [9:0]     push_data_nx;
    logic           push_q;
    logic [9:0]     push_data_q;

    logic [9:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, pop, push_ok, ovf_set;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    endfunction

    assign timeout_hit = (state != IDLE) && !byte_valid && (timer == TO_LAST);

    always_comb begin
        state_nx     = state;
        pause_nx     = pause_cnt;
        push_nx      = 1'b0;
        push_data_nx = 10'd0;
        fsm_err      = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    case (byte_data)
                        8'hE0: state_nx = EXT;
                        8'hF0: state_nx = BRK;
                        8'hE1: begin
                            state_nx = PAUSE;
                            pause_nx = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: state_nx = IDLE;
                        8'h00, 8'hFF: fsm_err = 1'b1;
                        default: begin
                            push_nx      = 1'b1;
                            push_data_nx = {2'b00, byte_data};
                        end
                    endcase
                end
                EXT: begin
                    if (byte_data == 8'hF0) begin
                        state_nx = EXT_BRK;
                    end else if (is_prefix(byte_data)) begin
                        state_nx = IDLE;
                        fsm_err  = 1'b1;
                    end else begin
                        state_nx     = IDLE;
                        push_nx      = 1'b1;
                        push_data_nx = {2'b01, byte_data};
                    end
                end
                BRK, EXT_BRK: begin
                    state_nx = IDLE;
                    if (is_prefix(byte_data)) begin
                        fsm_err = 1'b1;
                    end else begin
                        push_nx      = 1'b1;
                        push_data_nx = {1'b1, state == EXT_BRK, byte_data};
                    end
                end
                PAUSE: begin
                    pause_nx = pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        state_nx     = IDLE;
                        push_nx      = 1'b1;
                        push_data_nx = {2'b01, 8'h77};
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pause_cnt   <= 3'd0;
            timer       <= '0;
            push_q      <= 1'b0;
            push_data_q <= 10'd0;
        end else begin
            state       <= state_nx;
            pause_cnt   <= pause_nx;
            push_q      <= push_nx;
            push_data_q <= push_data_nx;
            if (byte_valid || state == IDLE)
                timer <= '0;
            else
                timer <= timer + TW'(1);
        end
    end

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_en && !empty;
    assign push_ok = push_q && (!full || pop);
    assign ovf_set = push_q && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data_q;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !push_ok)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (fsm_err || timeout_hit)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
            if (ovf_set)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;
        end
    end

    assign ev_valid = !empty;
    assign ev_data  = empty ? 10'd0 : mem[rd_ptr];
    assign ev_count = count;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl with a small FIFO and short timeout.
module tb_ps2_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rd_en;
    logic       clr_err;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic [2:0] ev_count;
    logic       err;
    logic       ovf;

    int n_pass = 0;
    int n_total = 0;

    ps2_key_event_ctrl #(.DEPTH(4), .TIMEOUT(50)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_count   (ev_count),
        .err        (err),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic chk_ev(input string name, input logic v, input logic [9:0] d, input logic [2:0] c);
        n_total++;
        if (ev_valid !== v || ev_data !== d || ev_count !== c)
            $display("FAIL %s: got valid=%b data=%h count=%0d, want valid=%b data=%h count=%0d",
                     name, ev_valid, ev_data, ev_count, v, d, c);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_ev("reset_fifo", 1'b0, 10'h000, 3'd0);
        n_total++;
        if ({err, ovf} !== 2'b00)
            $display("FAIL reset_status: got err=%b ovf=%b, want 0 0", err, ovf);
        else
            n_pass++;
    endtask

    task automatic test_make();
        send_byte(8'h1C);
        chk_ev("make_1c", 1'b1, 10'h01C, 3'd1);
        pop_one();
        chk_ev("make_pop", 1'b0, 10'h000, 3'd0);
    endtask

    task automatic test_latency();
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h2A;
        @(negedge clk);
        byte_valid = 1'b0;
        chk_ev("latency_1clk", 1'b0, 10'h000, 3'd0);
        @(negedge clk);
        chk_ev("latency_2clk", 1'b1, 10'h02A, 3'd1);
        pop_one();
    endtask

    task automatic test_ext_break();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk_ev("extbrk_head", 1'b1, 10'h375, 3'd2);
        pop_one();
        chk_ev("brk_second", 1'b1, 10'h21C, 3'd1);
        pop_one();
        send_byte(8'hE0);
        send_byte(8'h75);
        chk_ev("ext_make", 1'b1, 10'h175, 3'd1);
        pop_one();
        n_total++;
        if (err !== 1'b0)
            $display("FAIL extbrk_err: got err=%b, want 0", err);
        else
            n_pass++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++)
            send_byte(seq[i]);
        chk_ev("pause_event", 1'b1, 10'h177, 3'd1);
        n_total++;
        if (err !== 1'b0)
            $display("FAIL pause_err: got err=%b, want 0", err);
        else
            n_pass++;
        pop_one();
        send_byte(8'h1C);
        chk_ev("pause_then_idle", 1'b1, 10'h01C, 3'd1);
        pop_one();
    endtask

    task automatic test_timeout();
        send_byte(8'hE0);
        repeat (60) @(negedge clk);
        n_total++;
        if (err !== 1'b1 || ev_count !== 3'd0)
            $display("FAIL timeout_err: got err=%b count=%0d, want err=1 count=0", err, ev_count);
        else
            n_pass++;
        send_byte(8'h1C);
        chk_ev("timeout_next", 1'b1, 10'h01C, 3'd1);
        pulse_clr();
        n_total++;
        if (err !== 1'b0)
            $display("FAIL timeout_clr: got err=%b, want 0", err);
        else
            n_pass++;
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 5; i++)
            send_byte(codes[i]);
        chk_ev("ovf_full", 1'b1, 10'h015, 3'd4);
        n_total++;
        if (ovf !== 1'b1)
            $display("FAIL ovf_flag: got ovf=%b, want 1", ovf);
        else
            n_pass++;
        // push 35 lands in the same cycle as the pop
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h35;
        @(negedge clk);
        byte_valid = 1'b0;
        rd_en      = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk_ev("full_push_pop", 1'b1, 10'h01D, 3'd4);
        pop_one();
        chk_ev("drain_24", 1'b1, 10'h024, 3'd3);
        pop_one();
        chk_ev("drain_2d", 1'b1, 10'h02D, 3'd2);
        pop_one();
        chk_ev("drain_35", 1'b1, 10'h035, 3'd1);
        pop_one();
        chk_ev("drain_empty", 1'b0, 10'h000, 3'd0);
        pulse_clr();
        n_total++;
        if (ovf !== 1'b0)
            $display("FAIL ovf_clr: got ovf=%b, want 0", ovf);
        else
            n_pass++;
    endtask

    task automatic test_status_bytes();
        send_byte(8'hAA);
        send_byte(8'hFA);
        n_total++;
        if (err !== 1'b0 || ev_count !== 3'd0)
            $display("FAIL status_ignored: got err=%b count=%0d, want err=0 count=0", err, ev_count);
        else
            n_pass++;
        send_byte(8'h00);
        n_total++;
        if (err !== 1'b1 || ev_count !== 3'd0)
            $display("FAIL status_00: got err=%b count=%0d, want err=1 count=0", err, ev_count);
        else
            n_pass++;
        pulse_clr();
        send_byte(8'hE0);
        send_byte(8'hE1);
        n_total++;
        if (err !== 1'b1 || ev_count !== 3'd0)
            $display("FAIL ext_illegal: got err=%b count=%0d, want err=1 count=0", err, ev_count);
        else
            n_pass++;
        pulse_clr();
    endtask

    task automatic test_rst_mid();
        send_byte(8'h1C);
        send_byte(8'hF0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_ev("rst_mid_empty", 1'b0, 10'h000, 3'd0);
        n_total++;
        if (err !== 1'b0)
            $display("FAIL rst_mid_err: got err=%b, want 0", err);
        else
            n_pass++;
        send_byte(8'h1C);
        chk_ev("rst_mid_next", 1'b1, 10'h01C, 3'd1);
        pop_one();
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rd_en      = 1'b0;
        clr_err    = 1'b0;
        test_reset();
        test_make();
        test_latency();
        test_ext_break();
        test_pause();
        test_timeout();
        test_overflow();
        test_status_bytes();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
